// File: rtl/vga_sync_gen_pkg.sv
// rtl/vga_sync_gen_pkg.sv - 640x480@60 timing constants and coordinate type shared with the renderer
package vga_sync_gen_pkg;

    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam logic        VGA_SYNC_POL = 1'b0;

    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - VGA timing bundle from the sync generator to the renderer and connector
interface vga_sync_gen_if;

    logic                      Hsync;
    logic                      Vsync;
    logic                      Video_on;
    vga_sync_gen_pkg::coord_t  Pixel_x;
    vga_sync_gen_pkg::coord_t  Pixel_y;
    logic                      Line_start;
    logic                      Frame_start;

    modport master (
        output Hsync, Vsync, Video_on, Pixel_x, Pixel_y, Line_start, Frame_start
    );

    modport slave (
        input  Hsync, Vsync, Video_on, Pixel_x, Pixel_y, Line_start, Frame_start
    );

endinterface

// File: rtl/vga_sync_gen_axis_counter.sv
// rtl/vga_sync_gen_axis_counter.sv - wrapping 0..MAX counter with enable, exposing its next value
module vga_axis_counter #(
    parameter int unsigned MAX = 799,
    parameter int unsigned W   = 10
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_enable,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_next,
    output logic         o_wrap
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_next;
    logic         w_wrap;

    assign w_wrap = i_enable && (r_count == W'(MAX));

    always_comb begin
        w_next = r_count;
        if (w_wrap) begin
            w_next = '0;
        end else if (i_enable) begin
            w_next = r_count + W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;
    assign o_next  = w_next;
    assign o_wrap  = w_wrap;

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA sync/active/strobe generator; decodes the next coordinates so
// every output is registered alongside the pixel position it describes.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        SYNC_POL = VGA_SYNC_POL
) (
    input  logic               Pixel_clock,
    input  logic               Reset,
    vga_sync_gen_if.master     o_vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    if ((H_TOTAL > (32'd1 << COORD_W)) || (V_TOTAL > (32'd1 << COORD_W))) begin : g_timing_guard
        $error("vga_sync_gen: line or frame total exceeds the coordinate range");
    end

    coord_t w_x;
    coord_t w_x_next;
    coord_t w_y;
    coord_t w_y_next;
    logic   w_h_wrap;
    logic   w_v_wrap;

    logic   r_hsync;
    logic   r_vsync;
    logic   r_video_on;
    logic   r_line_start;
    logic   r_frame_start;

    vga_axis_counter #(.MAX(H_TOTAL - 1), .W(COORD_W)) u_h_cnt (
        .i_clk    (Pixel_clock),
        .i_reset  (Reset),
        .i_enable (1'b1),
        .o_count  (w_x),
        .o_next   (w_x_next),
        .o_wrap   (w_h_wrap)
    );

    vga_axis_counter #(.MAX(V_TOTAL - 1), .W(COORD_W)) u_v_cnt (
        .i_clk    (Pixel_clock),
        .i_reset  (Reset),
        .i_enable (w_h_wrap),
        .o_count  (w_y),
        .o_next   (w_y_next),
        .o_wrap   (w_v_wrap)
    );

    // Line wrap is exactly "next x == 0"; frame wrap is exactly "next (x,y) == (0,0)".
    always_ff @(posedge Pixel_clock) begin
        if (Reset) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= in_window(w_x_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= in_window(w_y_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= (w_x_next < coord_t'(H_ACTIVE)) && (w_y_next < coord_t'(V_ACTIVE));
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end
    end

    assign o_vga.Hsync       = r_hsync;
    assign o_vga.Vsync       = r_vsync;
    assign o_vga.Video_on    = r_video_on;
    assign o_vga.Pixel_x     = w_x;
    assign o_vga.Pixel_y     = w_y;
    assign o_vga.Line_start  = r_line_start;
    assign o_vga.Frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench: default 640x480 instance plus a tiny-timing instance for frame behaviour
module tb_vga_sync_gen;
    import vga_sync_gen_pkg::*;

    typedef struct { int ha, hf, hs, hb, va, vf, vs, vb; } tm_t;
    typedef struct { int x, y, hs, vs, von, ls, fs; } exp_t;

    localparam int B_HA = 8, B_HF = 2, B_HS = 3, B_HB = 2;
    localparam int B_VA = 5, B_VF = 1, B_VS = 2, B_VB = 2;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();

    vga_sync_gen u_dut_a (
        .Pixel_clock (clk),
        .Reset       (rst_a),
        .o_vga       (if_a)
    );

    vga_sync_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .SYNC_POL(1'b0)
    ) u_dut_b (
        .Pixel_clock (clk),
        .Reset       (rst_b),
        .o_vga       (if_b)
    );

    always #5 clk = ~clk;

    tm_t  ta, tb;
    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   mx_a = 0, my_a = 0, mx_b = 0, my_b = 0;
    int   hs_run_a = 0, hs_start_a = 0, last_ls_a = -1, prev_von_a = 0;
    int   vs_run_b = 0, last_fs_b = -1, prev_vs_b = 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t decode(tm_t t, int x, int y, logic rst);
        exp_t e;
        e.x = x;
        e.y = y;
        if (rst) begin
            e.hs = 1; e.vs = 1; e.von = 0; e.ls = 0; e.fs = 0;
        end else begin
            e.hs  = (x >= t.ha + t.hf && x < t.ha + t.hf + t.hs) ? 0 : 1;
            e.vs  = (y >= t.va + t.vf && y < t.va + t.vf + t.vs) ? 0 : 1;
            e.von = (x < t.ha && y < t.va) ? 1 : 0;
            e.ls  = (x == 0) ? 1 : 0;
            e.fs  = (x == 0 && y == 0) ? 1 : 0;
        end
        return e;
    endfunction

    task automatic advance(input tm_t t, input logic rst, inout int x, inout int y);
        int htot, vtot;
        htot = t.ha + t.hf + t.hs + t.hb;
        vtot = t.va + t.vf + t.vs + t.vb;
        if (rst) begin
            x = 0; y = 0;
        end else if (x == htot - 1) begin
            x = 0;
            y = (y == vtot - 1) ? 0 : y + 1;
        end else begin
            x = x + 1;
        end
    endtask

    function automatic exp_t sample_a();
        exp_t g;
        g.x = int'(if_a.Pixel_x);   g.y = int'(if_a.Pixel_y);
        g.hs = int'(if_a.Hsync);    g.vs = int'(if_a.Vsync);
        g.von = int'(if_a.Video_on);
        g.ls = int'(if_a.Line_start); g.fs = int'(if_a.Frame_start);
        return g;
    endfunction

    function automatic exp_t sample_b();
        exp_t g;
        g.x = int'(if_b.Pixel_x);   g.y = int'(if_b.Pixel_y);
        g.hs = int'(if_b.Hsync);    g.vs = int'(if_b.Vsync);
        g.von = int'(if_b.Video_on);
        g.ls = int'(if_b.Line_start); g.fs = int'(if_b.Frame_start);
        return g;
    endfunction

    task automatic compare(input string who, input exp_t g, input exp_t e);
        check({who, "_x"},   g.x,   e.x);
        check({who, "_y"},   g.y,   e.y);
        check({who, "_hs"},  g.hs,  e.hs);
        check({who, "_vs"},  g.vs,  e.vs);
        check({who, "_von"}, g.von, e.von);
        check({who, "_ls"},  g.ls,  e.ls);
        check({who, "_fs"},  g.fs,  e.fs);
    endtask

    task automatic tick();
        exp_t ea, eb, ga, gb;
        advance(ta, rst_a, mx_a, my_a);
        q_a.push_back(decode(ta, mx_a, my_a, rst_a));
        advance(tb, rst_b, mx_b, my_b);
        q_b.push_back(decode(tb, mx_b, my_b, rst_b));
        @(posedge clk);
        #1;
        cyc++;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        ga = sample_a();
        gb = sample_b();
        compare("a", ga, ea);
        compare("b", gb, eb);

        // Independent timing properties measured straight off the default-timing outputs
        if (rst_a) begin
            hs_run_a = 0; last_ls_a = -1;
        end else begin
            check("a_von_inv", ga.von, (ga.x < 640 && ga.y < 480) ? 1 : 0);
            check("a_x_range", (ga.x <= 799) ? 1 : 0, 1);
            check("a_y_range", (ga.y <= 524) ? 1 : 0, 1);
            if (ga.hs == 0) begin
                if (hs_run_a == 0) hs_start_a = ga.x;
                hs_run_a++;
            end else if (hs_run_a != 0) begin
                check("a_hs_width", hs_run_a, 96);
                check("a_hs_start_x", hs_start_a, 656);
                hs_run_a = 0;
            end
            if (ga.ls == 1) begin
                if (last_ls_a >= 0) check("a_ls_period", cyc - last_ls_a, 800);
                last_ls_a = cyc;
            end
            if (prev_von_a == 1 && ga.von == 0 && ga.y < 480) check("a_von_fall_x", ga.x, 640);
        end
        prev_von_a = ga.von;

        if (rst_b) begin
            vs_run_b = 0; last_fs_b = -1;
        end else begin
            check("b_von_inv", gb.von, (gb.x < B_HA && gb.y < B_VA) ? 1 : 0);
            if (gb.vs != prev_vs_b) check("b_vs_edge_x", gb.x, 0);
            if (gb.vs == 0) begin
                vs_run_b++;
            end else if (vs_run_b != 0) begin
                check("b_vs_width", vs_run_b, B_VS * (B_HA + B_HF + B_HS + B_HB));
                vs_run_b = 0;
            end
            if (gb.fs == 1) begin
                if (last_fs_b >= 0)
                    check("b_fs_period", cyc - last_fs_b,
                          (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB));
                last_fs_b = cyc;
            end
        end
        prev_vs_b = gb.vs;
    endtask

    initial begin
        int n;
        ta = '{640, 16, 96, 48, 480, 10, 2, 33};
        tb = '{B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB};

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (1700) tick();

        n = 0;
        while (mx_a != 700 && n < 1000) begin
            tick();
            n++;
        end
        check("a_at_700_x", int'(if_a.Pixel_x), 700);
        check("a_pre_rst_hs", int'(if_a.Hsync), 0);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        repeat (5) tick();

        n = 0;
        while (!(mx_b == 11 && my_b == 7) && n < 300) begin
            tick();
            n++;
        end
        check("b_at_11_7_x", int'(if_b.Pixel_x), 11);
        check("b_at_11_7_y", int'(if_b.Pixel_y), 7);
        check("b_pre_rst_hs", int'(if_b.Hsync), 0);
        check("b_pre_rst_vs", int'(if_b.Vsync), 0);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        repeat (400) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
